// File: rtl/multi_btn_led_pkg.sv
// Shared defaults and helpers for the multi-channel button/LED controller.
// Long-press support is enabled by defining MULTI_BTN_LONG_PRESS_EN.
package multi_btn_led_pkg;

    localparam int DEBOUNCE_CYCLES_DEF   = 4;
    localparam int LONG_PRESS_CYCLES_DEF = 64;
    localparam int CNT_W_DEF             = 4;

    typedef enum logic {
        BTN_PRESSED  = 1'b0,
        BTN_RELEASED = 1'b1
    } btn_lvl_e;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, debounced
// level and one-cycle press/release edge flags.
module btn_debounce
    import multi_btn_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o,
    output logic release_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    btn_lvl_e      state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    // The D-th consecutive mismatching sample commits the new level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            state_d = btn_lvl_e'(sync2_q);
            cnt_d   = '0;
            press_d = (sync2_q == BTN_PRESSED);
            rel_d   = (sync2_q == BTN_RELEASED);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= BTN_RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/multi_btn_led_ctrl.sv
// Multi-channel debounced button -> LED toggle and press counter.
// Optional long-press clear when MULTI_BTN_LONG_PRESS_EN is defined.
module multi_btn_led_ctrl
    import multi_btn_led_pkg::*;
#(
    parameter int NUM_CH            = 3,
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W             = CNT_W_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       btn_n,
    output logic [NUM_CH-1:0]       led_n,
    output logic [NUM_CH*CNT_W-1:0] press_cnt,
    output logic [NUM_CH-1:0]       press_pulse,
    output logic [NUM_CH-1:0]       long_pulse
);

`ifdef MULTI_BTN_LONG_PRESS_EN
    localparam int LW = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LP_MAX  = LW'(LONG_PRESS_CYCLES);
`else
    localparam int lp_unused = LONG_PRESS_CYCLES;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             press_w, rel_w;
        logic             led_q, led_d;
        logic             pulse_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_n_i  (btn_n[i]),
            .press_o  (press_w),
            .release_o(rel_w)
        );

`ifdef MULTI_BTN_LONG_PRESS_EN
        logic          armed_q, armed_d;
        logic          long_q, long_d;
        logic [LW-1:0] lp_q, lp_d;

        // Hold timer runs from the press event until release; it
        // saturates after firing so a single hold fires only once.
        always_comb begin
            led_d   = led_q;
            cnt_d   = cnt_q;
            armed_d = armed_q;
            long_d  = 1'b0;
            lp_d    = lp_q;
            if (press_w) begin
                led_d   = ~led_q;
                cnt_d   = cnt_q + 1'b1;
                lp_d    = '0;
                armed_d = 1'b1;
            end else if (rel_w) begin
                lp_d    = '0;
                armed_d = 1'b0;
            end else if (armed_q) begin
                if (lp_q == LP_LAST) begin
                    lp_d    = LP_MAX;
                    armed_d = 1'b0;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    led_d   = 1'b1;
                end else begin
                    lp_d = lp_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                armed_q <= 1'b0;
                long_q  <= 1'b0;
                lp_q    <= '0;
            end else begin
                armed_q <= armed_d;
                long_q  <= long_d;
                lp_q    <= lp_d;
            end
        end

        assign long_pulse[i] = long_q;
`else
        logic rel_unused;

        always_comb begin
            led_d = led_q;
            cnt_d = cnt_q;
            if (press_w) begin
                led_d = ~led_q;
                cnt_d = cnt_q + 1'b1;
            end
        end

        assign rel_unused    = rel_w;
        assign long_pulse[i] = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                led_q   <= 1'b1;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                led_q   <= led_d;
                cnt_q   <= cnt_d;
                pulse_q <= press_w;
            end
        end

        assign led_n[i]                   = led_q;
        assign press_pulse[i]             = pulse_q;
        assign press_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: doc/multi_btn_led_ctrl.md
MULTI_BTN_LED_CTRL -- requirements
Module: multi_btn_led_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3, number of independent button/LED channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a level change (>=1).
REQ-003 Parameter CNT_W, default 4, width of each per-channel press counter (>=1).
REQ-004 Parameter LONG_PRESS_CYCLES, default 64, stable-pressed cycles that define a long press (>DEBOUNCE_CYCLES).
REQ-005 clk  input  1  single system clock, rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 btn_n  input  NUM_CH  raw asynchronous buttons, active-low (0 = pressed).
REQ-008 led_n  output  NUM_CH  LED drive, active-low (0 = lit).
REQ-009 press_cnt  output  NUM_CH*CNT_W  per-channel press count, channel i at bits [i*CNT_W +: CNT_W].
REQ-010 press_pulse  output  NUM_CH  one-cycle strobe per accepted press.
REQ-011 long_pulse  output  NUM_CH  one-cycle strobe per accepted long press.

Function
REQ-012 Each btn_n bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-013 Each channel SHALL hold a debounced state; it SHALL change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any matching cycle resets the debounce count to 0.
REQ-014 A debounced released->pressed transition SHALL be a press event; press_pulse SHALL be high exactly one cycle, starting DEBOUNCE_CYCLES+2 cycles after the first clock edge sampling btn_n low (input held low throughout).
REQ-015 Pulses shorter than DEBOUNCE_CYCLES cycles (post-synchroniser) SHALL produce no event and no output change.
REQ-016 Debounced pressed->released transitions SHALL produce no event.
REQ-017 On a press event led_n[i] SHALL toggle and press_cnt[i] SHALL increment, both visible the same cycle press_pulse[i] is high.
REQ-018 press_cnt[i] SHALL wrap 2^CNT_W-1 -> 0 silently.
REQ-019 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be processed in the same cycle.
REQ-020 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); long-press counter width $clog2(LONG_PRESS_CYCLES+1), saturating.

Reset
REQ-021 rst_n low SHALL asynchronously force: synchroniser flops and debounced state to released (1), all counters 0, led_n all 1, press_cnt 0, press_pulse 0, long_pulse 0.
REQ-022 A button held low across reset deassertion SHALL yield one press event DEBOUNCE_CYCLES+2 cycles after the first post-reset edge.
REQ-023 Reset during an in-progress debounce SHALL discard it; no event is emitted for the aborted transition.

Configuration
REQ-024 Macro MULTI_BTN_LONG_PRESS_EN defined: when a channel stays debounced-pressed for LONG_PRESS_CYCLES cycles (counted from its press event), long_pulse[i] SHALL strobe one cycle, press_cnt[i] SHALL clear to 0 and led_n[i] SHALL go 1; at most once per hold; counter clears on release.
REQ-025 Macro undefined: long-press logic SHALL be absent, long_pulse SHALL be constant 0, port list unchanged.

Structure
REQ-026 Package multi_btn_led_pkg SHALL hold defaults (DEBOUNCE_CYCLES_DEF, LONG_PRESS_CYCLES_DEF, CNT_W_DEF) and the counter-width helper.
REQ-027 Sub-module btn_debounce (synchroniser, debounce counter, debounced state, press/release edge flags) SHALL be instantiated NUM_CH times; LED, counter and long-press logic stay in the top.

Verification
REQ-028 Reset, btn_n=all 1, DEBOUNCE_CYCLES=4 -> led_n=3'b111, press_cnt=0, no pulses for 100 cycles.
REQ-029 btn_n[0] low 10 cycles then high -> one press_pulse[0] 6 cycles after first low sample, led_n[0]=0, cnt0=1; nothing on release.
REQ-030 btn_n[1] low 3 cycles (glitch), repeated 5 times -> no pulses, outputs unchanged.
REQ-031 CNT_W=4, 17 clean presses on channel 2 -> cnt2=1 after wrap, led_n[2]=0 (17 toggles).
REQ-032 All three channels pressed on the same edge -> press_pulse=3'b111 in one cycle, each count 1.
REQ-033 MULTI_BTN_LONG_PRESS_EN, LONG_PRESS_CYCLES=64, channel 0 held 200 cycles after 2 presses -> single long_pulse[0], cnt0=0, led_n[0]=1; without macro long_pulse stays 0, cnt0=3.
